// File: rtl/fir_tap_sequencer_pkg.sv
`timescale 1ns/1ps
// fir_pkg: shared types and helpers for the FIR tap sequencer.
//   fir_seq_state_t : controller states (IDLE, MAC, OUT)
//   DEF_*           : default width / depth constants
//   tap_idx_w()     : width of a tap index for a given tap count
//   round_sat()     : round-half-up, arithmetic shift and saturate, used only
//                     when FIR_TAP_SEQUENCER_ROUND_SAT_EN is defined
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_seq_state_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_COEF_WIDTH = 16;
  localparam int DEF_NUM_TAPS   = 53;
  localparam int DEF_ACC_WIDTH  = 38;
  localparam int DEF_OUT_SHIFT  = 15;
  localparam int DEF_OUT_WIDTH  = 16;

  function automatic int tap_idx_w(input int num_taps);
    return (num_taps > 1) ? $clog2(num_taps) : 1;
  endfunction

  // Operates on a 64-bit sign-extended accumulator so one helper covers any
  // legal parameter set; the caller keeps the low out_w bits.
  function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                   input int shift,
                                                   input int out_w);
    logic signed [63:0] biased;
    logic signed [63:0] shifted;
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    biased  = (shift > 0) ? acc + (64'sd1 <<< (shift - 1)) : acc;
    shifted = biased >>> shift;
    max_v   = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v   = -(64'sd1 <<< (out_w - 1));
    if (shifted > max_v) begin
      return max_v;
    end else if (shifted < min_v) begin
      return min_v;
    end
    return shifted;
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_if.sv
`timescale 1ns/1ps
// fir_tap_sequencer_if: sample input handshake, result output handshake and
// coefficient write port of the FIR tap sequencer.
//   in_valid/in_ready/in_data     : one sample per handshake
//   out_valid/out_ready/out_data  : filtered result
//   coef_we/coef_addr/coef_wdata  : coefficient register file write port
// master = upstream/downstream environment, slave = fir_tap_sequencer.
interface fir_tap_sequencer_if
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int COEF_WIDTH = DEF_COEF_WIDTH,
  parameter int NUM_TAPS   = DEF_NUM_TAPS,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH
);

  localparam int TAP_IDX_W = tap_idx_w(NUM_TAPS);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] in_data;

  logic                         out_valid;
  logic                         out_ready;
  logic signed [OUT_WIDTH-1:0]  out_data;

  logic                         coef_we;
  logic [TAP_IDX_W-1:0]         coef_addr;
  logic signed [COEF_WIDTH-1:0] coef_wdata;

  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/fir_tap_sequencer_mac.sv
`timescale 1ns/1ps
// fir_mac: registered signed multiply-accumulate.
//   clk, reset : clock, synchronous active-high reset
//   clear      : zero the accumulator (takes priority over en)
//   en         : add a*b into the accumulator
//   a, b       : signed operands
//   acc_sum    : accumulator plus the current product, so the caller can
//                register the final sum in the same cycle as the last tap
module fir_mac #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int ACC_WIDTH  = 38
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [COEF_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc_sum
);

  localparam int PROD_WIDTH = DATA_WIDTH + COEF_WIDTH;

  logic signed [PROD_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]  product_ext;
  logic signed [ACC_WIDTH-1:0]  acc;

  assign product     = a * b;
  // Sized cast of a signed value sign-extends.
  assign product_ext = ACC_WIDTH'(product);
  assign acc_sum     = acc + product_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc_sum;
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
`timescale 1ns/1ps
// fir_tap_sequencer: time-multiplexed FIR controller. Accepts a sample,
// pulses the external tap chain shift, then walks every tap through a single
// MAC (one tap per cycle) and presents the filtered result.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : fir_tap_sequencer_if.slave (input/output handshakes and
//                coefficient write port)
//   chain_d    : data into the tap chain (copy of in_data)
//   chain_en   : chain shift enable, high on an input accept
//   chain_q    : chain taps, index 0 is the newest sample
//   busy       : high whenever not IDLE
// Build option: define FIR_TAP_SEQUENCER_ROUND_SAT_EN for round-half-up and
// saturation of the output; otherwise the output is a truncating bit slice.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int COEF_WIDTH = DEF_COEF_WIDTH,
  parameter int NUM_TAPS   = DEF_NUM_TAPS,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH,
  parameter int OUT_SHIFT  = DEF_OUT_SHIFT,
  parameter int OUT_WIDTH  = DEF_OUT_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  fir_tap_sequencer_if.slave           bus,
  output logic signed [DATA_WIDTH-1:0] chain_d,
  output logic                         chain_en,
  input  logic signed [DATA_WIDTH-1:0] chain_q [NUM_TAPS],
  output logic                         busy
);

  localparam int TAP_IDX_W = tap_idx_w(NUM_TAPS);
  localparam logic [TAP_IDX_W-1:0] LAST_TAP = TAP_IDX_W'(NUM_TAPS - 1);

  fir_seq_state_t               state;
  fir_seq_state_t               state_next;
  logic [TAP_IDX_W-1:0]         tap_idx;
  logic signed [COEF_WIDTH-1:0] coef [NUM_TAPS];
  logic                         accept;
  logic                         last_tap;
  logic                         mac_clear;
  logic                         mac_en;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [OUT_WIDTH-1:0]  out_next;

  assign chain_d  = bus.in_data;
  assign accept   = bus.in_valid && bus.in_ready;
  assign chain_en = accept;
  assign last_tap = (tap_idx == LAST_TAP);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // in_ready depends only on state, so accept never loops back into itself.
  always_comb begin
    state_next    = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b1;
    mac_clear     = 1'b0;
    mac_en        = 1'b0;
    unique case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        busy         = 1'b0;
        if (bus.in_valid) begin
          state_next = MAC;
          mac_clear  = 1'b1;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (last_tap) begin
          state_next = OUT;
        end
      end
      OUT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tap_idx <= '0;
    end else if (accept) begin
      tap_idx <= '0;
    end else if (state == MAC) begin
      tap_idx <= last_tap ? '0 : tap_idx + TAP_IDX_W'(1);
    end
  end

  // A write landing in the accept cycle is visible from the first MAC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        coef[i] <= '0;
      end
    end else if ((state == IDLE) && bus.coef_we && (bus.coef_addr <= LAST_TAP)) begin
      coef[bus.coef_addr] <= bus.coef_wdata;
    end
  end

  fir_mac #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clear   (mac_clear),
    .en      (mac_en),
    .a       (chain_q[tap_idx]),
    .b       (coef[tap_idx]),
    .acc_sum (acc_sum)
  );

`ifdef FIR_TAP_SEQUENCER_ROUND_SAT_EN
  assign out_next = OUT_WIDTH'(round_sat(64'(acc_sum), OUT_SHIFT, OUT_WIDTH));
`else
  // Arithmetic shift then keep the low bits: floor, wrapping when out of range.
  assign out_next = OUT_WIDTH'(acc_sum >>> OUT_SHIFT);
`endif

  // acc_sum on the last tap already includes the final product.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_data <= '0;
    end else if ((state == MAC) && last_tap) begin
      bus.out_data <= out_next;
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
`timescale 1ns/1ps
// tb_fir_tap_sequencer: drives fir_tap_sequencer with a tap chain model and
// compares every result with a sum-of-products reference model.
module tb_fir_tap_sequencer;
  import fir_pkg::*;

  localparam int DATA_WIDTH = 16;
  localparam int COEF_WIDTH = 16;
  localparam int NUM_TAPS   = 53;
  localparam int ACC_WIDTH  = 38;
  localparam int OUT_SHIFT  = 15;
  localparam int OUT_WIDTH  = 16;
  localparam int TAP_IDX_W  = tap_idx_w(NUM_TAPS);

  logic                         clk = 1'b0;
  logic                         reset;
  logic signed [DATA_WIDTH-1:0] chain_d;
  logic                         chain_en;
  logic signed [DATA_WIDTH-1:0] chain_q [NUM_TAPS];
  logic                         busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: accepted samples (newest first) and coefficient file.
  int hist  [NUM_TAPS];
  int coefm [NUM_TAPS];

  always #5 clk = ~clk;

  fir_tap_sequencer_if #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .NUM_TAPS   (NUM_TAPS),
    .OUT_WIDTH  (OUT_WIDTH)
  ) bus ();

  fir_tap_sequencer #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .NUM_TAPS   (NUM_TAPS),
    .ACC_WIDTH  (ACC_WIDTH),
    .OUT_SHIFT  (OUT_SHIFT),
    .OUT_WIDTH  (OUT_WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .chain_d  (chain_d),
    .chain_en (chain_en),
    .chain_q  (chain_q),
    .busy     (busy)
  );

  // External tap chain; cleared with the block so the model history matches.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_TAPS; i++) chain_q[i] <= '0;
    end else if (chain_en) begin
      chain_q[0] <= chain_d;
      for (int i = 1; i < NUM_TAPS; i++) chain_q[i] <= chain_q[i-1];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  function automatic logic [15:0] modelOut();
    longint sum;
    longint r;
    sum = 0;
    for (int k = 0; k < NUM_TAPS; k++) begin
      sum += longint'(hist[k]) * longint'(coefm[k]);
    end
`ifdef FIR_TAP_SEQUENCER_ROUND_SAT_EN
    r = (sum + (longint'(1) <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`else
    r = sum >>> OUT_SHIFT;
`endif
    return 16'(r);
  endfunction

  task automatic clearModel();
    for (int k = 0; k < NUM_TAPS; k++) begin
      hist[k]  = 0;
      coefm[k] = 0;
    end
  endtask

  // Coefficient write issued while the block is idle.
  task automatic applyCoef(input int addr, input logic signed [15:0] data);
    @(posedge clk); #1;
    bus.coef_we    = 1'b1;
    bus.coef_addr  = TAP_IDX_W'(addr);
    bus.coef_wdata = data;
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
    if (addr < NUM_TAPS) coefm[addr] = int'(data);
  endtask

  // One full sample: accept, MAC walk, optional output back-pressure, release.
  // With noisy set, in_valid and coefficient writes are toggled during MAC.
  task automatic applyStimulus(input logic signed [15:0] sample, input int hold,
                               input bit noisy, output logic [15:0] observed);
    logic [15:0] expected;
    logic [15:0] first;
    int cyc;
    bit en_seen, rdy_seen, idle_seen, unstable;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = sample;
    @(negedge clk);
    checkOutput("accept_ready", 32'(bus.in_ready), 1);
    checkOutput("accept_chain_en", 32'(chain_en), 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = NUM_TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = int'(sample);
    expected = modelOut();
    en_seen = 0; rdy_seen = 0; idle_seen = 0;
    for (cyc = 1; cyc <= 4 * NUM_TAPS; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      en_seen   |= chain_en;
      rdy_seen  |= bus.in_ready;
      idle_seen |= !busy;
      if (noisy) begin
        bus.in_valid   = 1'($urandom_range(0, 1));
        bus.in_data    = 16'($urandom);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = (cyc == 1) ? TAP_IDX_W'(3) : TAP_IDX_W'($urandom_range(0, NUM_TAPS - 1));
        bus.coef_wdata = (cyc == 1) ? 16'sh7FFF : 16'($urandom);
      end
    end
    checkOutput("latency", 32'(cyc), NUM_TAPS + 1);
    checkOutput("mac_chain_en", 32'(en_seen), 0);
    checkOutput("mac_in_ready", 32'(rdy_seen), 0);
    checkOutput("mac_busy", 32'(idle_seen), 0);
    first = bus.out_data;
    checkOutput("out_data", 32'(first), 32'(expected));
    if (hold > 0) begin
      unstable = 0;
      repeat (hold) begin
        @(negedge clk);
        if (bus.out_data !== first || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
          unstable = 1;
      end
      checkOutput("hold_stable", 32'(unstable), 0);
    end
    bus.in_valid  = 1'b0;
    bus.coef_we   = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    checkOutput("released_valid", 32'(bus.out_valid), 0);
    checkOutput("released_ready", 32'(bus.in_ready), 1);
    observed = first;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] obs;
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;
    clearModel();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 1);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 0);
    checkOutput("reset_out_data", 32'(bus.out_data), 0);
    checkOutput("reset_busy", 32'(busy), 0);

    // Impulse response; the first sample also exercises a 10-cycle stall.
    for (int k = 0; k < NUM_TAPS; k++) applyCoef(k, 16'(16'h0100 * (k + 1)));
    applyStimulus(16'sh7FFF, 10, 1'b0, obs);
    for (int k = 1; k < NUM_TAPS; k++) applyStimulus(16'sh0000, 0, 1'b0, obs);

    // Dropped writes: out-of-range address in IDLE, then writes during MAC.
    applyCoef(60, 16'sh1234);
    applyStimulus(16'sh7FFF, 0, 1'b1, obs);
    for (int k = 1; k < NUM_TAPS; k++) applyStimulus(16'sh0000, 0, 1'b0, obs);

    // DC gain.
    for (int k = 0; k < NUM_TAPS; k++) applyCoef(k, 16'sh0200);
    for (int k = 0; k < NUM_TAPS; k++) applyStimulus(16'sh1000, 0, 1'b0, obs);
    checkOutput("dc_gain", 32'(obs), 32'h0D40);

    // Full-scale positive and negative inputs with maximum coefficients.
    for (int k = 0; k < NUM_TAPS; k++) applyCoef(k, 16'sh7FFF);
    for (int k = 0; k < NUM_TAPS; k++) applyStimulus(16'sh7FFF, 0, 1'b0, obs);
`ifdef FIR_TAP_SEQUENCER_ROUND_SAT_EN
    checkOutput("overflow_pos", 32'(obs), 32'h7FFF);
`else
    checkOutput("overflow_pos", 32'(obs), 32'h7F96);
`endif
    for (int k = 0; k < NUM_TAPS; k++) applyStimulus(-16'sh8000, 0, 1'b0, obs);
`ifdef FIR_TAP_SEQUENCER_ROUND_SAT_EN
    checkOutput("overflow_neg", 32'(obs), 32'h8000);
`else
    checkOutput("overflow_neg", 32'(obs), 32'h8035);
`endif

    // Reset in the middle of the MAC walk.
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'sh1234;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    checkOutput("busy_before_reset", 32'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clearModel();
    @(negedge clk);
    checkOutput("midreset_busy", 32'(busy), 0);
    checkOutput("midreset_in_ready", 32'(bus.in_ready), 1);
    checkOutput("midreset_out_valid", 32'(bus.out_valid), 0);
    checkOutput("midreset_out_data", 32'(bus.out_data), 0);
    applyStimulus(16'sh7FFF, 0, 1'b0, obs);
    checkOutput("midreset_coef_zero", 32'(obs), 0);

    // Random coefficients, samples, stalls and MAC-time noise.
    for (int k = 0; k < NUM_TAPS; k++) applyCoef(k, 16'($urandom));
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 1) == 1) applyCoef($urandom_range(0, 63), 16'($urandom));
      applyStimulus(16'($urandom), $urandom_range(0, 4), 1'($urandom_range(0, 1)), obs);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
